// File: rtl/spc_aram_arbiter_if.sv
// rtl/spc_aram_arbiter_if.sv - bus bundle between the SPC CPU, DSP, debug port and audio RAM
// Groups:
//   CPU : CPU_ADDR, CPU_DOUT, CPU_WE_N -> arbiter;  CPU_RDY, CPU_DIN <- arbiter
//   DSP : DSP_REQ, DSP_ADDR, DSP_WE, DSP_WDATA -> arbiter;  DSP_ACK, DSP_RDATA <- arbiter
//   DBG : DBG_REQ, DBG_ADDR, DBG_WE, DBG_WDATA, DBG_HALT -> arbiter;  DBG_ACK, DBG_RDATA <- arbiter
//   RAM : RAM_ADDR, RAM_WDATA, RAM_WE <- arbiter;  RAM_RDATA -> arbiter
// slave modport is the arbiter side, master modport is the environment side.
interface spc_aram_arbiter_if;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DOUT;
    logic        CPU_WE_N;
    logic        CPU_RDY;
    logic [7:0]  CPU_DIN;

    logic        DSP_REQ;
    logic [15:0] DSP_ADDR;
    logic        DSP_WE;
    logic [7:0]  DSP_WDATA;
    logic        DSP_ACK;
    logic [7:0]  DSP_RDATA;

    logic        DBG_REQ;
    logic [15:0] DBG_ADDR;
    logic        DBG_WE;
    logic [7:0]  DBG_WDATA;
    logic        DBG_ACK;
    logic [7:0]  DBG_RDATA;
    logic        DBG_HALT;

    logic [15:0] RAM_ADDR;
    logic [7:0]  RAM_WDATA;
    logic        RAM_WE;
    logic [7:0]  RAM_RDATA;

    modport slave (
        input  CPU_ADDR, CPU_DOUT, CPU_WE_N,
        output CPU_RDY, CPU_DIN,
        input  DSP_REQ, DSP_ADDR, DSP_WE, DSP_WDATA,
        output DSP_ACK, DSP_RDATA,
        input  DBG_REQ, DBG_ADDR, DBG_WE, DBG_WDATA, DBG_HALT,
        output DBG_ACK, DBG_RDATA,
        output RAM_ADDR, RAM_WDATA, RAM_WE,
        input  RAM_RDATA
    );

    modport master (
        output CPU_ADDR, CPU_DOUT, CPU_WE_N,
        input  CPU_RDY, CPU_DIN,
        output DSP_REQ, DSP_ADDR, DSP_WE, DSP_WDATA,
        input  DSP_ACK, DSP_RDATA,
        output DBG_REQ, DBG_ADDR, DBG_WE, DBG_WDATA, DBG_HALT,
        input  DBG_ACK, DBG_RDATA,
        input  RAM_ADDR, RAM_WDATA, RAM_WE,
        output RAM_RDATA
    );
endinterface

// File: rtl/spc_aram_arbiter.sv
// rtl/spc_aram_arbiter.sv - time-slotted audio RAM arbiter for the SPC CPU, DSP and debug port
// Ports:
//   CLK   : clock
//   RST_N : asynchronous active-low reset
//   bus   : spc_aram_arbiter_if.slave (CPU step/read/write, DSP and DBG request/ack, sync RAM)
// Each CPU step is a frame of CPU_DIV slots. Slot 0 issues the CPU read, slot 1's edge
// captures the read data, the last slot pulses CPU_RDY and carries any CPU write. All other
// slots (and the CPU slots while the debugger halts the CPU) are shared round-robin by DSP/DBG.
module spc_aram_arbiter #(
    parameter int CPU_DIV = 4
) (
    input  logic CLK,
    input  logic RST_N,
    spc_aram_arbiter_if.slave bus
);
    localparam int SW = $clog2(CPU_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(CPU_DIV - 1);
    localparam logic [SW-1:0] SLOT_DIN  = SW'(1);

    logic [SW-1:0] slot_q;
    logic          halt_f_q;
    logic          prio_dbg_q;   // 1: DBG wins a tie (DSP was granted most recently)
    logic          dsp_ack_q;
    logic          dbg_ack_q;
    logic [7:0]    cpu_din_q;

    logic slot_first, slot_last;
    logic cpu_rd, cpu_rdy, cpu_wr, free_slot;
    logic dsp_elig, dbg_elig, gnt_dsp, gnt_dbg;

    always_comb begin
        slot_first = (slot_q == '0);
        slot_last  = (slot_q == SLOT_LAST);
        // RST_N gating keeps the RAM idle and CPU stalled while reset is held.
        cpu_rd     = RST_N && slot_first && !bus.DBG_HALT;
        cpu_rdy    = RST_N && slot_last && !halt_f_q;
        cpu_wr     = cpu_rdy && !bus.CPU_WE_N;
        // Slot 0 uses the live DBG_HALT (halt_f is only latched at its end);
        // the last slot follows the frame's latched halt flag.
        free_slot  = RST_N && ((!slot_first && !slot_last)
                               || (slot_first && bus.DBG_HALT)
                               || (slot_last && halt_f_q));
        // A requester whose ACK is showing this cycle sits out one slot.
        dsp_elig   = free_slot && bus.DSP_REQ && !dsp_ack_q;
        dbg_elig   = free_slot && bus.DBG_REQ && !dbg_ack_q;
        gnt_dsp    = dsp_elig && (!dbg_elig || !prio_dbg_q);
        gnt_dbg    = dbg_elig && !gnt_dsp;
    end

    always_comb begin
        bus.RAM_ADDR  = '0;
        bus.RAM_WDATA = '0;
        bus.RAM_WE    = 1'b0;
        if (cpu_rd) begin
            bus.RAM_ADDR = bus.CPU_ADDR;
        end else if (cpu_wr) begin
            bus.RAM_ADDR  = bus.CPU_ADDR;
            bus.RAM_WDATA = bus.CPU_DOUT;
            bus.RAM_WE    = 1'b1;
        end else if (gnt_dsp) begin
            bus.RAM_ADDR  = bus.DSP_ADDR;
            bus.RAM_WDATA = bus.DSP_WDATA;
            bus.RAM_WE    = bus.DSP_WE;
        end else if (gnt_dbg) begin
            bus.RAM_ADDR  = bus.DBG_ADDR;
            bus.RAM_WDATA = bus.DBG_WDATA;
            bus.RAM_WE    = bus.DBG_WE;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_q     <= '0;
            halt_f_q   <= 1'b1;
            prio_dbg_q <= 1'b0;
            dsp_ack_q  <= 1'b0;
            dbg_ack_q  <= 1'b0;
            cpu_din_q  <= 8'h00;
        end else begin
            slot_q <= slot_last ? '0 : slot_q + 1'b1;
            if (slot_first) begin
                halt_f_q <= bus.DBG_HALT;
            end
            // halt_f_q already holds this frame's value during slot 1.
            if (slot_q == SLOT_DIN && !halt_f_q) begin
                cpu_din_q <= bus.RAM_RDATA;
            end
            dsp_ack_q <= gnt_dsp;
            dbg_ack_q <= gnt_dbg;
            if (gnt_dsp) begin
                prio_dbg_q <= 1'b1;
            end else if (gnt_dbg) begin
                prio_dbg_q <= 1'b0;
            end
        end
    end

    assign bus.CPU_RDY   = cpu_rdy;
    assign bus.CPU_DIN   = cpu_din_q;
    assign bus.DSP_ACK   = dsp_ack_q;
    assign bus.DBG_ACK   = dbg_ack_q;
    assign bus.DSP_RDATA = dsp_ack_q ? bus.RAM_RDATA : 8'h00;
    assign bus.DBG_RDATA = dbg_ack_q ? bus.RAM_RDATA : 8'h00;
endmodule

// File: tb/tb_spc_aram_arbiter.sv
// tb/tb_spc_aram_arbiter.sv - self-checking bench for spc_aram_arbiter (CPU_DIV=4)
module tb_spc_aram_arbiter;
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    spc_aram_arbiter_if bus();

    spc_aram_arbiter #(.CPU_DIV(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Synchronous RAM: address/WE sampled at the edge, read data valid next cycle.
    logic [7:0] mem [0:65535];
    always @(posedge CLK) begin
        if (bus.RAM_WE) mem[bus.RAM_ADDR] <= bus.RAM_WDATA;
        bus.RAM_RDATA <= mem[bus.RAM_ADDR];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected requester completions.
    typedef struct {
        logic       is_dbg;
        logic       chk_data;
        logic [7:0] data;
    } sb_t;
    sb_t sbq[$];

    always @(negedge CLK) begin
        if (RST_N === 1'b1 && (bus.DSP_ACK === 1'b1 || bus.DBG_ACK === 1'b1)) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got dsp=%0b dbg=%0b expected none", bus.DSP_ACK, bus.DBG_ACK);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if ((e.is_dbg ? bus.DBG_ACK : bus.DSP_ACK) !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_ack_source: got dsp=%0b dbg=%0b expected is_dbg=%0b", bus.DSP_ACK, bus.DBG_ACK, e.is_dbg);
                end else if (e.chk_data && (e.is_dbg ? bus.DBG_RDATA : bus.DSP_RDATA) !== e.data) begin
                    errors++;
                    $display("FAIL sb_rdata: got %0h expected %0h", e.is_dbg ? bus.DBG_RDATA : bus.DSP_RDATA, e.data);
                end
            end
        end
    end

    typedef struct {
        logic        dsp_req, dbg_req, dbg_we;
        logic [15:0] dbg_addr;
        logic        halt;
        logic [15:0] cpu_addr;
        logic        cpu_we_n;
        logic        exp_rdy, exp_we, chk_addr;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd, exp_din;
        logic [1:0]  gnt;      // 0 none, 1 DSP read, 2 DBG read, 3 DBG write
        logic [7:0]  gnt_data;
    } vec_t;

    function automatic vec_t mk(input logic dsp, dbg, dwe, input logic [15:0] daddr,
                                input logic halt, input logic [15:0] caddr, input logic cwen,
                                input logic rdy, we, ca, input logic [15:0] ea,
                                input logic [7:0] ewd, din, input logic [1:0] gnt,
                                input logic [7:0] gd);
        vec_t v;
        v.dsp_req = dsp; v.dbg_req = dbg; v.dbg_we = dwe; v.dbg_addr = daddr;
        v.halt = halt; v.cpu_addr = caddr; v.cpu_we_n = cwen;
        v.exp_rdy = rdy; v.exp_we = we; v.chk_addr = ca; v.exp_addr = ea;
        v.exp_wd = ewd; v.exp_din = din; v.gnt = gnt; v.gnt_data = gd;
        return v;
    endfunction

    vec_t vec [36];
    int   k_ack;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h1234] = 8'h5A;
        mem[16'h0100] = 8'h11;
        mem[16'h0200] = 8'h22;

        //            dsp dbg dwe daddr     hlt caddr     wen  rdy we ca eaddr     ewd    din    g gdata
        // frame: plain CPU read of 0x1234
        vec[0]  = mk(0,0,0,16'h0000, 0,16'h1234,1, 0,0,1,16'h1234,8'h00,8'h00, 0,8'h00);
        vec[1]  = mk(0,0,0,16'h0000, 0,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h00, 0,8'h00);
        vec[2]  = mk(0,0,0,16'h0000, 0,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[3]  = mk(0,0,0,16'h0000, 0,16'h1234,1, 1,0,0,16'h0000,8'h00,8'h5A, 0,8'h00);
        // frame: CPU write 0x77 to 0x00F4
        vec[4]  = mk(0,0,0,16'h0000, 0,16'h00F4,0, 0,0,1,16'h00F4,8'h00,8'h5A, 0,8'h00);
        vec[5]  = mk(0,0,0,16'h0000, 0,16'h00F4,0, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[6]  = mk(0,0,0,16'h0000, 0,16'h00F4,0, 0,0,1,16'h0000,8'h00,8'h00, 0,8'h00);
        vec[7]  = mk(0,0,0,16'h0000, 0,16'h00F4,0, 1,1,1,16'h00F4,8'h77,8'h00, 0,8'h00);
        // frame: read back 0x00F4
        vec[8]  = mk(0,0,0,16'h0000, 0,16'h00F4,1, 0,0,1,16'h00F4,8'h00,8'h00, 0,8'h00);
        vec[9]  = mk(0,0,0,16'h0000, 0,16'h00F4,1, 0,0,1,16'h0000,8'h00,8'h00, 0,8'h00);
        vec[10] = mk(0,0,0,16'h0000, 0,16'h00F4,1, 0,0,1,16'h0000,8'h00,8'h77, 0,8'h00);
        vec[11] = mk(0,0,0,16'h0000, 0,16'h00F4,1, 1,0,0,16'h0000,8'h00,8'h77, 0,8'h00);
        // two frames: DSP (0x0100) and DBG (0x0200) both requesting
        vec[12] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h1234,8'h00,8'h77, 0,8'h00);
        vec[13] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h0100,8'h00,8'h77, 1,8'h11);
        vec[14] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h0200,8'h00,8'h5A, 2,8'h22);
        vec[15] = mk(1,1,0,16'h0200, 0,16'h1234,1, 1,0,0,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[16] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h1234,8'h00,8'h5A, 0,8'h00);
        vec[17] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h0100,8'h00,8'h5A, 1,8'h11);
        vec[18] = mk(1,1,0,16'h0200, 0,16'h1234,1, 0,0,1,16'h0200,8'h00,8'h5A, 2,8'h22);
        vec[19] = mk(0,0,0,16'h0200, 0,16'h1234,1, 1,0,0,16'h0000,8'h00,8'h5A, 0,8'h00);
        // halt rises at slot 2: RDY still at slot 3
        vec[20] = mk(0,0,0,16'h0000, 0,16'h1234,1, 0,0,1,16'h1234,8'h00,8'h5A, 0,8'h00);
        vec[21] = mk(0,0,0,16'h0000, 0,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[22] = mk(0,0,0,16'h0000, 1,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[23] = mk(0,0,0,16'h0000, 1,16'h1234,1, 1,0,0,16'h0000,8'h00,8'h5A, 0,8'h00);
        // halted frame: DBG writes 0xAB to 0x8000 in slots 0 and 2
        vec[24] = mk(0,1,1,16'h8000, 1,16'h1234,1, 0,1,1,16'h8000,8'hAB,8'h5A, 3,8'h00);
        vec[25] = mk(0,1,1,16'h8000, 1,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[26] = mk(0,1,1,16'h8000, 1,16'h1234,1, 0,1,1,16'h8000,8'hAB,8'h5A, 3,8'h00);
        vec[27] = mk(0,0,1,16'h8000, 1,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        // halted frame, halt released at slot 1: DBG writes in slots 1 and 3, no RDY
        vec[28] = mk(0,0,1,16'h8000, 1,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[29] = mk(0,1,1,16'h8000, 0,16'h1234,1, 0,1,1,16'h8000,8'hAB,8'h5A, 3,8'h00);
        vec[30] = mk(0,1,1,16'h8000, 0,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[31] = mk(0,1,1,16'h8000, 0,16'h1234,1, 0,1,1,16'h8000,8'hAB,8'h5A, 3,8'h00);
        // running again; DBG reads back 0x8000
        vec[32] = mk(0,0,0,16'h8000, 0,16'h1234,1, 0,0,1,16'h1234,8'h00,8'h5A, 0,8'h00);
        vec[33] = mk(0,1,0,16'h8000, 0,16'h1234,1, 0,0,1,16'h8000,8'h00,8'h5A, 2,8'hAB);
        vec[34] = mk(0,0,0,16'h8000, 0,16'h1234,1, 0,0,1,16'h0000,8'h00,8'h5A, 0,8'h00);
        vec[35] = mk(0,0,0,16'h8000, 0,16'h1234,1, 1,0,0,16'h0000,8'h00,8'h5A, 0,8'h00);

        // Reset with a halted debugger write pending: RAM must stay idle.
        RST_N = 1'b0;
        bus.CPU_ADDR = 16'h1234; bus.CPU_DOUT = 8'h77; bus.CPU_WE_N = 1'b1;
        bus.DSP_REQ = 1'b0; bus.DSP_ADDR = 16'h0100; bus.DSP_WE = 1'b0; bus.DSP_WDATA = 8'h00;
        bus.DBG_REQ = 1'b1; bus.DBG_ADDR = 16'h8000; bus.DBG_WE = 1'b1; bus.DBG_WDATA = 8'hAB;
        bus.DBG_HALT = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("reset_cpu_rdy", bus.CPU_RDY, 1'b0);
        chk("reset_ram_we", bus.RAM_WE, 1'b0);
        chk("reset_cpu_din", bus.CPU_DIN, 8'h00);
        chk("reset_dsp_ack", bus.DSP_ACK, 1'b0);
        chk("reset_dbg_ack", bus.DBG_ACK, 1'b0);
        chk("reset_dbg_rdata", bus.DBG_RDATA, 8'h00);
        bus.DBG_REQ = 1'b0; bus.DBG_WE = 1'b0; bus.DBG_HALT = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;   // this cycle is slot 0

        for (int i = 0; i < 36; i++) begin
            bus.DSP_REQ  = vec[i].dsp_req;
            bus.DBG_REQ  = vec[i].dbg_req;
            bus.DBG_WE   = vec[i].dbg_we;
            bus.DBG_ADDR = vec[i].dbg_addr;
            bus.DBG_HALT = vec[i].halt;
            bus.CPU_ADDR = vec[i].cpu_addr;
            bus.CPU_WE_N = vec[i].cpu_we_n;
            if (vec[i].gnt != 2'd0) begin
                sb_t e;
                e.is_dbg   = (vec[i].gnt != 2'd1);
                e.chk_data = (vec[i].gnt != 2'd3);
                e.data     = vec[i].gnt_data;
                sbq.push_back(e);
            end
            @(negedge CLK);
            chk($sformatf("v%0d_cpu_rdy", i), bus.CPU_RDY, vec[i].exp_rdy);
            chk($sformatf("v%0d_ram_we", i), bus.RAM_WE, vec[i].exp_we);
            chk($sformatf("v%0d_cpu_din", i), bus.CPU_DIN, vec[i].exp_din);
            if (vec[i].chk_addr) chk($sformatf("v%0d_ram_addr", i), bus.RAM_ADDR, vec[i].exp_addr);
            if (vec[i].exp_we) chk($sformatf("v%0d_ram_wdata", i), bus.RAM_WDATA, vec[i].exp_wd);
            @(posedge CLK); #1;
        end
        chk("sb_drained_after_table", sbq.size(), 0);

        // Reset pulse during a DSP grant cycle (slot 1).
        bus.DSP_REQ = 1'b0; bus.DBG_REQ = 1'b0; bus.DBG_HALT = 1'b0;
        @(posedge CLK); #1;
        bus.DSP_REQ = 1'b1; bus.DSP_ADDR = 16'h0100;
        @(negedge CLK);
        chk("pre_reset_dsp_grant_addr", bus.RAM_ADDR, 16'h0100);
        #1 RST_N = 1'b0;
        #1;
        chk("async_reset_ram_we", bus.RAM_WE, 1'b0);
        chk("async_reset_cpu_din", bus.CPU_DIN, 8'h00);
        chk("async_reset_cpu_rdy", bus.CPU_RDY, 1'b0);
        @(posedge CLK); #1;
        chk("reset_no_dsp_ack", bus.DSP_ACK, 1'b0);
        chk("reset_dsp_rdata", bus.DSP_RDATA, 8'h00);
        @(posedge CLK); #1;
        RST_N = 1'b1;   // slot 0 again, DSP_REQ still held
        begin
            sb_t e;
            e.is_dbg = 1'b0; e.chk_data = 1'b1; e.data = 8'h11;
            sbq.push_back(e);
        end
        k_ack = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (bus.DSP_ACK === 1'b1) begin
                k_ack = k;
                break;
            end
        end
        bus.DSP_REQ = 1'b0;
        chk("dsp_regrant_ack_cycle", k_ack, 2);
        repeat (4) @(posedge CLK);
        #1;
        chk("sb_drained_at_end", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
